vga_score_counter: RTL and testbench



---
 rtl/vga_score_counter.sv | 128 ++++++++++++
 tb/tb_vga_score_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_score_counter.sv
// Packed-BCD score keeper: serial one-digit-per-clock increment, frame-stable display snapshot.
// Optional high-score tracking is built when SCORE_HIGHSCORE_EN is defined.
module vga_score_counter #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned PEND_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_rst,
  input  logic                   eat,
  input  logic                   frame_start,
  output logic [4*NDIGITS-1:0]   score_bcd,
  output logic [4*NDIGITS-1:0]   disp_bcd,
  output logic [4*NDIGITS-1:0]   high_bcd,
  output logic                   busy,
  output logic                   sat
);

  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {IDLE, INC} state_t;

  state_t               state, state_n;
  logic [PEND_W-1:0]    pending, pending_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [4*NDIGITS-1:0] score_n, disp_n;
  logic                 sat_n, latch_pend, latch_pend_n;
  logic                 all_nines, take;

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (score_bcd[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    idx_n        = idx;
    score_n      = score_bcd;
    disp_n       = disp_bcd;
    sat_n        = sat;
    latch_pend_n = latch_pend;
    take         = eat && (pending != PEND_MAX);

    if (game_rst) begin
      state_n      = IDLE;
      pending_n    = '0;
      idx_n        = '0;
      score_n      = '0;
      sat_n        = 1'b0;
      latch_pend_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Score is stable while IDLE, so this never captures a torn carry.
          if (frame_start || latch_pend) begin
            disp_n       = score_bcd;
            latch_pend_n = 1'b0;
          end
          if ((pending != '0) && all_nines) begin
            pending_n = '0;
            sat_n     = 1'b1;
          end else if (pending != '0) begin
            state_n   = INC;
            idx_n     = '0;
            pending_n = take ? pending : pending - 1'b1;
          end else if (take) begin
            pending_n = pending + 1'b1;
          end
        end
        INC: begin
          if (frame_start) latch_pend_n = 1'b1;
          if (take) pending_n = pending + 1'b1;
          for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
              if (score_bcd[4*i +: 4] == 4'd9) begin
                score_n[4*i +: 4] = '0;
                idx_n             = idx + 1'b1;
              end else begin
                score_n[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
                state_n           = IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      idx        <= '0;
      score_bcd  <= '0;
      disp_bcd   <= '0;
      sat        <= 1'b0;
      latch_pend <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      idx        <= idx_n;
      score_bcd  <= score_n;
      disp_bcd   <= disp_n;
      sat        <= sat_n;
      latch_pend <= latch_pend_n;
    end
  end

`ifdef SCORE_HIGHSCORE_EN
  // Unsigned vector compare is valid because BCD ordering is monotone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_bcd <= '0;
    end else if (game_rst && (score_bcd > high_bcd)) begin
      high_bcd <= score_bcd;
    end
  end
`else
  assign high_bcd = '0;
`endif

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_vga_score_counter.sv
// Self-checking bench for vga_score_counter: integer-score reference model plus directed literal checks.
module tb_vga_score_counter;

  localparam int PMAX = 7;
  localparam int SMAX = 9999;

  logic        clk = 1'b0;
  logic        reset, game_rst, eat, frame_start;
  logic [15:0] score_bcd, disp_bcd, high_bcd;
  logic        busy, sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_score_counter #(.NDIGITS(4), .PEND_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .game_rst    (game_rst),
    .eat         (eat),
    .frame_start (frame_start),
    .score_bcd   (score_bcd),
    .disp_bcd    (disp_bcd),
    .high_bcd    (high_bcd),
    .busy        (busy),
    .sat         (sat)
  );

  // Reference model: committed score as an integer, an in-flight increment tracked
  // by how many trailing nines have been cleared so far.
  int m_score = 0, m_pend = 0, m_j = 0, m_t = 0, m_disp = 0, m_high = 0, m_acc = 0;
  bit m_inc = 0, m_latch = 0, m_sat = 0;

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int nines(int v);
    int c = 0;
    while (c < 4 && (v % 10) == 9) begin
      c++;
      v = v / 10;
    end
    return c;
  endfunction

  function automatic int shown();
    return m_inc ? m_score - (pow10(m_j) - 1) : m_score;
  endfunction

  function automatic logic [15:0] hi(logic [15:0] v);
`ifdef SCORE_HIGHSCORE_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_score = 0; m_pend = 0; m_j = 0; m_disp = 0; m_high = 0;
        m_inc = 0; m_latch = 0; m_sat = 0;
      end else if (game_rst) begin
`ifdef SCORE_HIGHSCORE_EN
        if (shown() > m_high) m_high = shown();
`endif
        m_score = 0; m_pend = 0; m_j = 0; m_inc = 0; m_latch = 0; m_sat = 0;
      end else begin
        m_acc = (eat && m_pend < PMAX) ? 1 : 0;
        if (!m_inc) begin
          if (frame_start || m_latch) begin
            m_disp  = m_score;
            m_latch = 0;
          end
          if (m_pend != 0 && m_score == SMAX) begin
            m_pend = 0;
            m_sat  = 1;
          end else if (m_pend != 0) begin
            m_inc  = 1;
            m_j    = 0;
            m_t    = nines(m_score);
            m_pend = m_pend - 1 + m_acc;
          end else begin
            m_pend = m_pend + m_acc;
          end
        end else begin
          if (frame_start) m_latch = 1;
          m_pend = m_pend + m_acc;
          if (m_j == m_t) begin
            m_score = m_score + 1;
            m_inc   = 0;
            m_j     = 0;
          end else begin
            m_j = m_j + 1;
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("score_model", score_bcd, to_bcd(shown()));
    chk("disp_model",  disp_bcd,  to_bcd(m_disp));
    chk("high_model",  high_bcd,  to_bcd(m_high));
    chk("busy_model",  busy,      (m_inc || m_pend != 0));
    chk("sat_model",   sat,       m_sat);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_game_rst();
    game_rst = 1'b1; tick(); game_rst = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin tick(); g++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic count_to(int target);
    int g = 0;
    while ((m_score != target || m_inc || m_pend != 0) && g < 40000) begin
      eat = ((m_score + m_pend + (m_inc ? 1 : 0)) < target) && (m_pend < PMAX);
      tick();
      g++;
    end
    eat = 1'b0;
    chk("count_to", score_bcd, to_bcd(target));
  endtask

  initial begin
    reset = 1'b1; game_rst = 1'b0; eat = 1'b0; frame_start = 1'b0;
    tick(); tick();
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_disp",  disp_bcd,  16'h0000);
    chk("rst_busy",  busy,      1'b0);
    reset = 1'b0;
    tick();

    // Single eat: digit 0 updates at edge k+2.
    eat = 1'b1; tick(); eat = 1'b0;
    chk("one_k0_busy", busy, 1'b1);
    chk("one_k0_score", score_bcd, 16'h0000);
    tick();
    chk("one_k1_busy", busy, 1'b1);
    tick();
    chk("one_k2_score", score_bcd, 16'h0001);
    chk("one_k2_busy", busy, 1'b0);
    chk("one_k2_disp", disp_bcd, 16'h0000);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("one_snap", disp_bcd, 16'h0001);

    // Long carry with a deferred snapshot.
    count_to(999);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("c999_snap", disp_bcd, 16'h0999);
    eat = 1'b1; tick(); eat = 1'b0;
    tick(); tick();
    chk("c999_k2_torn", score_bcd, 16'h0990);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("c999_k3_torn", score_bcd, 16'h0900);
    tick();
    chk("c999_k4_torn", score_bcd, 16'h0000);
    chk("c999_k4_disp", disp_bcd, 16'h0999);
    tick();
    chk("c999_k5_score", score_bcd, 16'h1000);
    chk("c999_k5_disp", disp_bcd, 16'h0999);
    tick();
    chk("c999_k6_disp", disp_bcd, 16'h1000);

    // Asynchronous reset in the middle of INC.
    eat = 1'b1; tick(); eat = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("amid_score", score_bcd, 16'h0000);
    chk("amid_disp",  disp_bcd,  16'h0000);
    chk("amid_busy",  busy,      1'b0);
    chk("amid_high",  high_bcd,  16'h0000);
    tick(); reset = 1'b0;
    eat = 1'b1; tick(); eat = 1'b0;
    tick(); tick();
    chk("post_rst_score", score_bcd, 16'h0001);

    // High score across games; eat coincident with game_rst is dropped.
    count_to(30);
    pulse_game_rst();
    chk("g1_score", score_bcd, 16'h0000);
    chk("g1_high", high_bcd, hi(16'h0030));
    count_to(42);
    game_rst = 1'b1; eat = 1'b1; tick(); game_rst = 1'b0; eat = 1'b0;
    chk("g2_score", score_bcd, 16'h0000);
    chk("g2_busy", busy, 1'b0);
    chk("g2_high", high_bcd, hi(16'h0042));
    tick(); tick();
    chk("g2_eat_dropped", score_bcd, 16'h0000);
    count_to(10);
    pulse_game_rst();
    chk("g3_high", high_bcd, hi(16'h0042));

    // Twenty consecutive eats: pending saturates and four eats are dropped.
    eat = 1'b1; repeat (20) tick(); eat = 1'b0;
    wait_idle();
    chk("burst_score", score_bcd, 16'h0016);

    // Saturation at all nines.
    pulse_game_rst();
    count_to(9999);
    eat = 1'b1; tick(); eat = 1'b0;
    chk("sat_k0_busy", busy, 1'b1);
    chk("sat_k0_sat", sat, 1'b0);
    tick();
    chk("sat_k1_sat", sat, 1'b1);
    chk("sat_k1_busy", busy, 1'b0);
    chk("sat_k1_score", score_bcd, 16'h9999);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      eat         = ($urandom % 3) != 0;
      frame_start = ($urandom % 12) == 0;
      game_rst    = ($urandom % 400) == 0;
      tick();
    end
    eat = 1'b0; frame_start = 1'b0; game_rst = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
